// File: rtl/gate_chk_pkg.sv
// Shared types for the gate truth-table sequencer: reference-function codes,
// FSM states and the truth-table size.
package gate_chk_pkg;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NAND = 3'd2,
    GATE_NOR  = 3'd3,
    GATE_XOR  = 3'd4,
    GATE_XNOR = 3'd5,
    GATE_BUF  = 3'd6,
    GATE_NOT  = 3'd7
  } gate_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam int unsigned NUM_VECTORS = 4;

endpackage

// File: rtl/gate_truth_table_driver_if.sv
// Stimulus/response bundle between the sequencer (slave) and its user (master).
interface gate_truth_table_driver_if #(
  parameter int unsigned ERR_W = 4
);
  logic             start;
  logic [2:0]       gate_sel;
  logic             y;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_vec;

  modport master (
    output start, gate_sel, y,
    input  a, b, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    input  start, gate_sel, y,
    output a, b, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_ref_model.sv
// Combinational reference for the 2-input gate under test.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  gate_sel_e sel_i,
  input  logic      a_i,
  input  logic      b_i,
  output logic      exp_o
);

  always_comb begin
    exp_o = 1'b0;
    unique case (sel_i)
      GATE_AND:  exp_o = a_i & b_i;
      GATE_OR:   exp_o = a_i | b_i;
      GATE_NAND: exp_o = ~(a_i & b_i);
      GATE_NOR:  exp_o = ~(a_i | b_i);
      GATE_XOR:  exp_o = a_i ^ b_i;
      GATE_XNOR: exp_o = ~(a_i ^ b_i);
      GATE_BUF:  exp_o = a_i;
      GATE_NOT:  exp_o = ~a_i;
    endcase
  end

endmodule

// File: rtl/gate_truth_table_driver.sv
// Sweeps a,b through 00..11, waits a settle window, samples y against the
// selected reference function and accumulates mismatch results.
module gate_truth_table_driver
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 10,
  parameter int unsigned NUM_PASSES    = 1,
  parameter int unsigned ERR_W         = 4
) (
  input logic                      clk,
  input logic                      rst,
  gate_truth_table_driver_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0] LAST_PASS   = PASS_W'(NUM_PASSES - 1);
  localparam logic [1:0]        LAST_VEC    = 2'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

  state_e            state_q, state_d;
  gate_sel_e         sel_q, sel_d;
  logic [1:0]        vec_q, vec_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              a_q, a_d, b_q, b_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [3:0]        fail_q, fail_d;
  logic              pass_q, pass_d;
  logic              exp_y;

  gate_ref_model u_ref (
    .sel_i (sel_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .exp_o (exp_y)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    vec_d      = vec_q;
    pass_cnt_d = pass_cnt_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    err_d      = err_q;
    fail_d     = fail_q;
    pass_d     = pass_q;
    unique case (state_q)
      ST_IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (bus.start) begin
          sel_d      = gate_sel_e'(bus.gate_sel);
          err_d      = '0;
          fail_d     = '0;
          pass_d     = 1'b0;
          vec_d      = '0;
          pass_cnt_d = '0;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        a_d     = vec_q[1];
        b_d     = vec_q[0];
        cnt_d   = SETTLE_LOAD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_SAMPLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_SAMPLE: begin
        if (bus.y != exp_y) begin
          fail_d[vec_q] = 1'b1;
          if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
        end
        if (vec_q != LAST_VEC) begin
          vec_d   = vec_q + 2'd1;
          state_d = ST_DRIVE;
        end else if (pass_cnt_q != LAST_PASS) begin
          vec_d      = '0;
          pass_cnt_d = pass_cnt_q + PASS_W'(1);
          state_d    = ST_DRIVE;
        end else begin
          // Uses err_d so the final compare is included and pass is valid alongside done.
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        a_d     = 1'b0;
        b_d     = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= GATE_AND;
      vec_q      <= '0;
      pass_cnt_q <= '0;
      cnt_q      <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      err_q      <= '0;
      fail_q     <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      vec_q      <= vec_d;
      pass_cnt_q <= pass_cnt_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
      pass_q     <= pass_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_truth_table_driver.sv
// Directed bench for the gate truth-table sequencer: two instances, one with
// default parameters and one running 20 passes for saturation.
module tb_gate_truth_table_driver;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  // y source: 0 = ideal OR of a,b; 1 = tied 0; 2 = tied 1
  logic [1:0] y_mode1;

  gate_truth_table_driver_if #(.ERR_W(4)) bus1 ();
  gate_truth_table_driver_if #(.ERR_W(4)) bus2 ();

  gate_truth_table_driver #(.SETTLE_CYCLES(10), .NUM_PASSES(1), .ERR_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  gate_truth_table_driver #(.SETTLE_CYCLES(10), .NUM_PASSES(20), .ERR_W(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  assign bus1.y = (y_mode1 == 2'd0) ? (bus1.a | bus1.b) :
                  (y_mode1 == 2'd1) ? 1'b0 : 1'b1;
  assign bus2.y = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start on dut1 for one accepting edge, then counts edges until done.
  task automatic run1(input logic [2:0] sel, output int cyc);
    bus1.gate_sel = sel;
    bus1.start    = 1'b1;
    tick();
    bus1.start = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus1.done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass} !== 5'b0 ||
        bus1.err_count !== 4'd0 || bus1.fail_vec !== 4'd0) begin
      $display("FAIL reset_outputs: a,b,busy,done,pass=%b err=%0d fail_vec=%b required all zero",
               {bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass}, bus1.err_count, bus1.fail_vec);
      n_fail++;
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
      $display("FAIL reset_idle: busy=%b done=%b required 0 0", bus1.busy, bus1.done);
      n_fail++;
    end
  endtask

  task automatic test_or_ideal();
    int cyc;
    logic [1:0] exp_ab [4];
    int         at     [4];
    exp_ab[0] = 2'b00; exp_ab[1] = 2'b01; exp_ab[2] = 2'b10; exp_ab[3] = 2'b11;
    at[0] = 1; at[1] = 13; at[2] = 25; at[3] = 37;
    y_mode1       = 2'd0;
    bus1.gate_sel = 3'd1;
    bus1.start    = 1'b1;
    tick();
    bus1.start = 1'b0;
    n_tests++;
    if (bus1.busy !== 1'b1) begin
      $display("FAIL or_busy_after_accept: busy=%b required 1", bus1.busy);
      n_fail++;
    end
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      for (int v = 0; v < 4; v++) begin
        if (i == at[v]) begin
          n_tests++;
          if ({bus1.a, bus1.b} !== exp_ab[v]) begin
            $display("FAIL or_vector%0d: ab=%b required %b", v, {bus1.a, bus1.b}, exp_ab[v]);
            n_fail++;
          end
        end
      end
      if (bus1.done) begin
        cyc = i;
        break;
      end
    end
    n_tests++;
    if (cyc != 48) begin
      $display("FAIL or_latency: done after %0d cycles required 48", cyc);
      n_fail++;
    end
    n_tests++;
    if (bus1.pass !== 1'b1 || bus1.err_count !== 4'd0 || bus1.fail_vec !== 4'b0000 || bus1.busy !== 1'b0) begin
      $display("FAIL or_result: pass=%b err=%0d fail_vec=%b busy=%b required 1 0 0000 0",
               bus1.pass, bus1.err_count, bus1.fail_vec, bus1.busy);
      n_fail++;
    end
    tick();
    n_tests++;
    if (bus1.done !== 1'b0 || bus1.pass !== 1'b1 || {bus1.a, bus1.b} !== 2'b00) begin
      $display("FAIL or_after_done: done=%b pass=%b ab=%b required 0 1 00",
               bus1.done, bus1.pass, {bus1.a, bus1.b});
      n_fail++;
    end
  endtask

  task automatic test_stuck0();
    int cyc;
    y_mode1 = 2'd1;
    run1(3'd1, cyc);
    n_tests++;
    if (cyc != 48) begin
      $display("FAIL stuck0_latency: done after %0d cycles required 48", cyc);
      n_fail++;
    end
    n_tests++;
    if (bus1.err_count !== 4'd3 || bus1.fail_vec !== 4'b1110 || bus1.pass !== 1'b0) begin
      $display("FAIL stuck0_result: err=%0d fail_vec=%b pass=%b required 3 1110 0",
               bus1.err_count, bus1.fail_vec, bus1.pass);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_and_vs_or();
    int cyc;
    y_mode1 = 2'd0;
    run1(3'd0, cyc);
    n_tests++;
    if (cyc != 48 || bus1.err_count !== 4'd2 || bus1.fail_vec !== 4'b0110 || bus1.pass !== 1'b0) begin
      $display("FAIL and_vs_or: cyc=%0d err=%0d fail_vec=%b pass=%b required 48 2 0110 0",
               cyc, bus1.err_count, bus1.fail_vec, bus1.pass);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    int cyc;
    logic saw_done;
    y_mode1       = 2'd2;
    bus1.gate_sel = 3'd0;
    bus1.start    = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int i = 1; i <= 20; i++) tick();
    n_tests++;
    if (bus1.err_count !== 4'd1 || bus1.fail_vec !== 4'b0001) begin
      $display("FAIL midrun_pre: err=%0d fail_vec=%b required 1 0001", bus1.err_count, bus1.fail_vec);
      n_fail++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({bus1.a, bus1.b, bus1.busy, bus1.done} !== 4'b0 || bus1.err_count !== 4'd0 || bus1.fail_vec !== 4'd0) begin
      $display("FAIL midrun_reset: a,b,busy,done=%b err=%0d fail_vec=%b required zeros",
               {bus1.a, bus1.b, bus1.busy, bus1.done}, bus1.err_count, bus1.fail_vec);
      n_fail++;
    end
    saw_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus1.done || bus1.busy) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done !== 1'b0) begin
      $display("FAIL midrun_no_done: activity=%b required 0", saw_done);
      n_fail++;
    end
    y_mode1 = 2'd0;
    run1(3'd1, cyc);
    n_tests++;
    if (cyc != 48 || bus1.pass !== 1'b1) begin
      $display("FAIL midrun_rerun: cyc=%0d pass=%b required 48 1", cyc, bus1.pass);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_saturate();
    int cyc;
    bus2.gate_sel = 3'd0;
    bus2.start    = 1'b1;
    tick();
    bus2.start = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 2000; i++) begin
      tick();
      if (bus2.done) begin
        cyc = i;
        break;
      end
    end
    n_tests++;
    if (cyc != 960) begin
      $display("FAIL sat_latency: done after %0d cycles required 960", cyc);
      n_fail++;
    end
    n_tests++;
    if (bus2.err_count !== 4'd15 || bus2.fail_vec !== 4'b0111 || bus2.pass !== 1'b0) begin
      $display("FAIL sat_result: err=%0d fail_vec=%b pass=%b required 15 0111 0",
               bus2.err_count, bus2.fail_vec, bus2.pass);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    y_mode1       = 2'd1;
    bus1.gate_sel = 3'd1;
    bus1.start    = 1'b1;
    tick();
    bus1.start = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      bus1.start = (i == 10) || (i >= 45);
      tick();
      if (bus1.done) begin
        cyc = i;
        break;
      end
    end
    n_tests++;
    if (cyc != 48 || bus1.err_count !== 4'd3 || bus1.fail_vec !== 4'b1110) begin
      $display("FAIL b2b_first: cyc=%0d err=%0d fail_vec=%b required 48 3 1110",
               cyc, bus1.err_count, bus1.fail_vec);
      n_fail++;
    end
    tick();
    n_tests++;
    if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.err_count !== 4'd3) begin
      $display("FAIL b2b_idle: busy=%b done=%b err=%0d required 0 0 3",
               bus1.busy, bus1.done, bus1.err_count);
      n_fail++;
    end
    tick();
    bus1.start = 1'b0;
    y_mode1    = 2'd0;
    n_tests++;
    if (bus1.busy !== 1'b1 || bus1.err_count !== 4'd0 || bus1.fail_vec !== 4'd0 || bus1.pass !== 1'b0) begin
      $display("FAIL b2b_accept: busy=%b err=%0d fail_vec=%b pass=%b required 1 0 0000 0",
               bus1.busy, bus1.err_count, bus1.fail_vec, bus1.pass);
      n_fail++;
    end
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus1.done) begin
        cyc = i;
        break;
      end
    end
    n_tests++;
    if (cyc != 48 || bus1.pass !== 1'b1 || bus1.err_count !== 4'd0) begin
      $display("FAIL b2b_second: cyc=%0d pass=%b err=%0d required 48 1 0", cyc, bus1.pass, bus1.err_count);
      n_fail++;
    end
    tick();
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    y_mode1       = 2'd0;
    rst           = 1'b1;
    bus1.start    = 1'b0;
    bus1.gate_sel = 3'd0;
    bus2.start    = 1'b0;
    bus2.gate_sel = 3'd0;
    test_reset();
    test_or_ideal();
    test_stuck0();
    test_and_vs_or();
    test_reset_midrun();
    test_saturate();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
